// File: rtl/dmem_copy_engine_if.sv
// Data-memory port of unified_memory as seen by the copy engine.
// W_Data connects to SrcB_Reg_M on the memory side.
interface dmem_copy_engine_if #(
  parameter int ADDR_W = 12
);
  logic              MEM_W_En;
  logic [2:0]        MEM_Control;
  logic [ADDR_W-1:0] RW_Addr;
  logic [31:0]       W_Data;
  logic [31:0]       R_Data;

  modport master (output MEM_W_En, MEM_Control, RW_Addr, W_Data, input R_Data);
  modport slave  (input MEM_W_En, MEM_Control, RW_Addr, W_Data, output R_Data);
endinterface

// File: rtl/dmem_copy_engine.sv
// Word copy/fill engine driving the data-memory port while Busy is high.
// Fill mode (Mode=1) is only built when DMA_FILL_EN is defined.
module dmem_copy_engine #(
  parameter int         ADDR_W   = 12,
  parameter int         LEN_W    = 10,
  parameter int         RD_LAT   = 2,
  parameter logic [2:0] MEM_WORD = 3'b010
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Mode,
  input  logic [ADDR_W-1:0]  Src_Addr,
  input  logic [ADDR_W-1:0]  Dst_Addr,
  input  logic [LEN_W-1:0]   Len,
  input  logic [31:0]        Fill_Data,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  dmem_copy_engine_if.master mem
);

  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d, wen_q, wen_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                fill_q, fill_req;
  logic [31:0]         fill_data;

`ifdef DMA_FILL_EN
  assign fill_req  = Mode;
  assign fill_data = Fill_Data;

  always_ff @(posedge CLK) begin
    if (!RST)                         fill_q <= 1'b0;
    else if (state_q == IDLE && Start) fill_q <= Mode;
  end
`else
  // Fill path tied off so the write-data mux collapses to R_Data.
  assign fill_req  = 1'b0;
  assign fill_data = '0;
  assign fill_q    = 1'b0;
  wire unused_fill = ^{Mode, Fill_Data};
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wen_d   = 1'b0;
    unique case (state_q)
      IDLE: if (Start) begin
        if (Src_Addr[1:0] != 2'b00 || Dst_Addr[1:0] != 2'b00) begin
          err_d = 1'b1;
        end else if (Len == '0) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          src_d  = Src_Addr;
          dst_d  = Dst_Addr;
          rem_d  = Len;
          busy_d = 1'b1;
          if (fill_req) begin
            state_d = WR;
            addr_d  = Dst_Addr;
            wdata_d = fill_data;
            wen_d   = 1'b1;
          end else begin
            state_d = RD;
            addr_d  = Src_Addr;
          end
        end
      end
      RD, WAIT: begin
        if (RD_LAT == 0 || (state_q == WAIT && wcnt_q == '0)) begin
          state_d = WR;
          addr_d  = dst_q;
          wdata_d = mem.R_Data;
          wen_d   = 1'b1;
        end else begin
          state_d = WAIT;
          wcnt_d  = (state_q == RD) ? WAIT_INIT : wcnt_q - 1'b1;
        end
      end
      WR: begin
        src_d = src_q + WORD_STEP;
        dst_d = dst_q + WORD_STEP;
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (fill_q) begin
          addr_d  = dst_q + WORD_STEP;
          wdata_d = fill_data;
          wen_d   = 1'b1;
        end else begin
          state_d = RD;
          addr_d  = src_q + WORD_STEP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over any progression; issued writes are left in memory.
    if (Abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wen_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
    end
  end

  assign Busy            = busy_q;
  assign Done            = done_q;
  assign Err             = err_q;
  assign mem.MEM_W_En    = wen_q;
  assign mem.MEM_Control = MEM_WORD;
  assign mem.RW_Addr     = addr_q;
  assign mem.W_Data      = wdata_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine against a 2-cycle-latency word memory.
module tb_dmem_copy_engine;

  localparam logic [2:0] EXP_CTRL = 3'b010;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start, Abort, Mode;
  logic [11:0] Src_Addr, Dst_Addr;
  logic [9:0]  Len;
  logic [31:0] Fill_Data;
  logic        Busy, Done, Err;

  int checks = 0;
  int errors = 0;

  dmem_copy_engine_if #(.ADDR_W(12)) mem_if ();

  dmem_copy_engine dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .Mode(Mode),
    .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr), .Len(Len), .Fill_Data(Fill_Data),
    .Busy(Busy), .Done(Done), .Err(Err), .mem(mem_if)
  );

  always #5 CLK = ~CLK;

  // memory model: address sampled at edge n+1, data sampled by DUT at edge n+3
  bit [31:0] ram_block [0:1023];
  logic [31:0] rd_a1 = '0, rd_q = '0;
  int wr_count = 0;
  logic        pre_we = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_data = '0;

  assign mem_if.R_Data = rd_q;

  always @(posedge CLK) begin
    rd_a1 <= ram_block[mem_if.RW_Addr[11:2]];
    rd_q  <= rd_a1;
    if (mem_if.MEM_W_En) begin
      ram_block[mem_if.RW_Addr[11:2]] <= mem_if.W_Data;
      wr_count <= wr_count + 1;
    end else if (pre_we) begin
      ram_block[pre_idx] <= pre_data;
    end
  end

  function automatic logic [31:0] pat(input int i);
    return 32'h1000 + 32'(i * 3);
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge CLK);
    pre_idx = idx; pre_data = val; pre_we = 1'b1;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  // returns at the negedge right after the edge that sampled Start (c=0)
  task automatic issue(input logic [11:0] s, input logic [11:0] d, input logic [9:0] l,
                       input logic m, input logic [31:0] f);
    @(negedge CLK);
    Src_Addr = s; Dst_Addr = d; Len = l; Mode = m; Fill_Data = f; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic watch(input int ncyc, input int abort_at, output int done_at, output int done_n,
                       output int busy_n, output int wen_n, output int err_at);
    done_at = -1; done_n = 0; busy_n = 0; wen_n = 0; err_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge CLK);
      Abort = (c == abort_at);
      if (Done) begin done_n++; if (done_at < 0) done_at = c; end
      if (Err && err_at < 0) err_at = c;
      if (Busy) busy_n++;
      if (mem_if.MEM_W_En) wen_n++;
    end
    Abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks += 7;
    if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %0h exp 0", Done); end
    if (Err !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", Err); end
    if (mem_if.MEM_W_En !== 1'b0) begin errors++; $display("FAIL rst_wen got %0h exp 0", mem_if.MEM_W_En); end
    if (mem_if.MEM_Control !== EXP_CTRL) begin errors++; $display("FAIL rst_ctrl got %0h exp %0h", mem_if.MEM_Control, EXP_CTRL); end
    if (mem_if.RW_Addr !== 12'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", mem_if.RW_Addr); end
    if (mem_if.W_Data !== 32'h0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", mem_if.W_Data); end
  endtask

  task automatic test_copy();
    int da, dn, bn, wn, ea, w0;
    w0 = wr_count;
    issue(12'h000, 12'h100, 10'd3, 1'b0, 32'h0);
    watch(16, -1, da, dn, bn, wn, ea);
    checks += 8;
    if (da !== 12) begin errors++; $display("FAIL copy_done_at got %0d exp 12", da); end
    if (dn !== 1) begin errors++; $display("FAIL copy_done_n got %0d exp 1", dn); end
    if (bn !== 12) begin errors++; $display("FAIL copy_busy got %0d exp 12", bn); end
    if (wn !== 3) begin errors++; $display("FAIL copy_wen got %0d exp 3", wn); end
    if (wr_count - w0 !== 3) begin errors++; $display("FAIL copy_writes got %0d exp 3", wr_count - w0); end
    if (ram_block[64] !== 32'h10) begin errors++; $display("FAIL copy_w0 got %0h exp 10", ram_block[64]); end
    if (ram_block[65] !== 32'h20) begin errors++; $display("FAIL copy_w1 got %0h exp 20", ram_block[65]); end
    if (ram_block[66] !== 32'h30) begin errors++; $display("FAIL copy_w2 got %0h exp 30", ram_block[66]); end
  endtask

  task automatic test_fill();
    int da, dn, bn, wn, ea;
    logic [31:0] exp_w;
    issue(12'h200, 12'h040, 10'd16, 1'b1, 32'hDEADBEEF);
`ifdef DMA_FILL_EN
    watch(20, -1, da, dn, bn, wn, ea);
    checks += 2;
    if (da !== 16) begin errors++; $display("FAIL fill_done_at got %0d exp 16", da); end
    if (wn !== 16) begin errors++; $display("FAIL fill_wen got %0d exp 16", wn); end
`else
    watch(70, -1, da, dn, bn, wn, ea);
    checks += 2;
    if (da !== 64) begin errors++; $display("FAIL fill_as_copy_done_at got %0d exp 64", da); end
    if (wn !== 16) begin errors++; $display("FAIL fill_as_copy_wen got %0d exp 16", wn); end
`endif
    for (int i = 0; i < 16; i++) begin
`ifdef DMA_FILL_EN
      exp_w = 32'hDEADBEEF;
`else
      exp_w = pat(i);
`endif
      checks++;
      if (ram_block[16 + i] !== exp_w) begin
        errors++; $display("FAIL fill_word%0d got %0h exp %0h", i, ram_block[16 + i], exp_w);
      end
    end
  endtask

  task automatic test_len_zero();
    int da, dn, bn, wn, ea;
    issue(12'h000, 12'h180, 10'd0, 1'b0, 32'h0);
    watch(5, -1, da, dn, bn, wn, ea);
    checks += 4;
    if (da !== 0) begin errors++; $display("FAIL len0_done_at got %0d exp 0", da); end
    if (dn !== 1) begin errors++; $display("FAIL len0_done_n got %0d exp 1", dn); end
    if (wn !== 0) begin errors++; $display("FAIL len0_wen got %0d exp 0", wn); end
    if (bn !== 0) begin errors++; $display("FAIL len0_busy got %0d exp 0", bn); end
  endtask

  task automatic test_misaligned();
    int da, dn, bn, wn, ea, w0;
    w0 = wr_count;
    issue(12'h002, 12'h100, 10'd3, 1'b0, 32'h0);
    watch(8, -1, da, dn, bn, wn, ea);
    checks += 5;
    if (ea !== 0) begin errors++; $display("FAIL mis_err_at got %0d exp 0", ea); end
    if (bn !== 0) begin errors++; $display("FAIL mis_busy got %0d exp 0", bn); end
    if (dn !== 0) begin errors++; $display("FAIL mis_done got %0d exp 0", dn); end
    if (wr_count - w0 !== 0) begin errors++; $display("FAIL mis_writes got %0d exp 0", wr_count - w0); end
    if (ram_block[64] !== 32'h10) begin errors++; $display("FAIL mis_mem got %0h exp 10", ram_block[64]); end
  endtask

  task automatic test_abort();
    int da, dn, bn, wn, ea, w0;
    w0 = wr_count;
    issue(12'h200, 12'h300, 10'd8, 1'b0, 32'h0);
    watch(14, 9, da, dn, bn, wn, ea);
    checks += 8;
    if (dn !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", dn); end
    if (ea !== -1) begin errors++; $display("FAIL abort_err_at got %0d exp -1", ea); end
    if (bn !== 10) begin errors++; $display("FAIL abort_busy got %0d exp 10", bn); end
    if (wr_count - w0 !== 2) begin errors++; $display("FAIL abort_writes got %0d exp 2", wr_count - w0); end
    if (ram_block[192] !== pat(0)) begin errors++; $display("FAIL abort_w0 got %0h exp %0h", ram_block[192], pat(0)); end
    if (ram_block[193] !== pat(1)) begin errors++; $display("FAIL abort_w1 got %0h exp %0h", ram_block[193], pat(1)); end
    if (ram_block[194] !== 32'h0) begin errors++; $display("FAIL abort_w2 got %0h exp 0", ram_block[194]); end
    issue(12'h200, 12'h3A0, 10'd1, 1'b0, 32'h0);
    watch(8, -1, da, dn, bn, wn, ea);
    if (da !== 4) begin errors++; $display("FAIL abort_restart got %0d exp 4", da); end
    checks++;
    if (ram_block[232] !== pat(0)) begin errors++; $display("FAIL abort_restart_w got %0h exp %0h", ram_block[232], pat(0)); end
  endtask

  task automatic test_reset_mid();
    int da, dn, bn, wn, ea;
    issue(12'h000, 12'h140, 10'd2, 1'b0, 32'h0);
    repeat (3) @(negedge CLK);
    checks++;
    if (mem_if.MEM_W_En !== 1'b1) begin errors++; $display("FAIL rmid_in_wr got %0h exp 1", mem_if.MEM_W_En); end
    RST = 1'b0;
    @(negedge CLK);
    checks += 6;
    if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0h exp 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL rmid_done got %0h exp 0", Done); end
    if (mem_if.MEM_W_En !== 1'b0) begin errors++; $display("FAIL rmid_wen got %0h exp 0", mem_if.MEM_W_En); end
    if (mem_if.RW_Addr !== 12'h0) begin errors++; $display("FAIL rmid_addr got %0h exp 0", mem_if.RW_Addr); end
    if (mem_if.W_Data !== 32'h0) begin errors++; $display("FAIL rmid_wdata got %0h exp 0", mem_if.W_Data); end
    if (mem_if.MEM_Control !== EXP_CTRL) begin errors++; $display("FAIL rmid_ctrl got %0h exp %0h", mem_if.MEM_Control, EXP_CTRL); end
    RST = 1'b1;
    issue(12'h000, 12'h140, 10'd3, 1'b0, 32'h0);
    watch(16, -1, da, dn, bn, wn, ea);
    checks += 4;
    if (da !== 12) begin errors++; $display("FAIL rmid_copy_done got %0d exp 12", da); end
    if (ram_block[80] !== 32'h10) begin errors++; $display("FAIL rmid_w0 got %0h exp 10", ram_block[80]); end
    if (ram_block[81] !== 32'h20) begin errors++; $display("FAIL rmid_w1 got %0h exp 20", ram_block[81]); end
    if (ram_block[82] !== 32'h30) begin errors++; $display("FAIL rmid_w2 got %0h exp 30", ram_block[82]); end
  endtask

  task automatic test_wrap();
    int da, dn, bn, wn, ea;
    issue(12'h200, 12'hFFC, 10'd2, 1'b0, 32'h0);
    watch(12, -1, da, dn, bn, wn, ea);
    checks += 4;
    if (da !== 8) begin errors++; $display("FAIL wrap_done_at got %0d exp 8", da); end
    if (ea !== -1) begin errors++; $display("FAIL wrap_err got %0d exp -1", ea); end
    if (ram_block[1023] !== pat(0)) begin errors++; $display("FAIL wrap_w0 got %0h exp %0h", ram_block[1023], pat(0)); end
    if (ram_block[0] !== pat(1)) begin errors++; $display("FAIL wrap_w1 got %0h exp %0h", ram_block[0], pat(1)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0; Start = 1'b0; Abort = 1'b0; Mode = 1'b0;
    Src_Addr = '0; Dst_Addr = '0; Len = '0; Fill_Data = '0;
    repeat (3) @(posedge CLK);
    test_reset();
    RST = 1'b1;
    poke(0, 32'h10); poke(1, 32'h20); poke(2, 32'h30);
    for (int i = 0; i < 16; i++) poke(128 + i, pat(i));
    test_copy();
    test_fill();
    test_len_zero();
    test_misaligned();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
